// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexes a packed hex value onto one shared seven-segment decoder.
// Double-buffered loads, optional leading-zero blanking and a per-slot blanking gap.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    dp_n,
    output logic                    frame_start,
    output logic                    load_pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Position registers describe the cycle currently on the outputs.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  started_q;
    state_t                state_q, state_d;
    logic [VAL_W-1:0]      active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q, frame_start_d;

    logic                  frame_edge;
    logic                  slot_blank;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  all_zero;
    logic                  dp_sel;
    logic                  lz_sel;

    always_comb begin
        cnt_d = '0;
        idx_d = '0;
        if (started_q) begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    assign frame_edge = (cnt_d == '0) && (idx_d == '0);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign slot_blank = 1'b0;
        end else begin : g_blank
            assign slot_blank = (cnt_d < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    assign state_d = slot_blank ? ST_BLANK : ST_DRIVE;

    // A load on the transfer edge lands in the shadow while the old shadow moves to active.
    always_comb begin
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        if (frame_edge && pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
        end
        shadow_val_d = load ? value_in : shadow_val_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (frame_edge) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (active_val_d[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_blank_en && all_zero;
        end
    end

    always_comb begin
        nibble_d   = 4'h0;
        dp_sel     = 1'b0;
        lz_sel     = 1'b0;
        digit_en_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble_d = active_val_d[4*i +: 4];
                dp_sel   = active_dp_d[i];
                lz_sel   = lz_mask[i];
                digit_en_d[i] = !((state_d == ST_DRIVE) && !lz_mask[i]);
            end
        end
        dp_d          = !((state_d == ST_DRIVE) && !lz_sel && dp_sel);
        frame_start_d = frame_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            started_q     <= 1'b0;
            state_q       <= ST_BLANK;
            active_val_q  <= '0;
            active_dp_q   <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            nibble_q      <= 4'h0;
            digit_en_q    <= '1;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            started_q     <= 1'b1;
            state_q       <= state_d;
            active_val_q  <= active_val_d;
            active_dp_q   <= active_dp_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            nibble_q      <= nibble_d;
            digit_en_q    <= digit_en_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign nibble_out   = nibble_q;
    assign digit_en_n   = digit_en_q;
    assign dp_n         = dp_q;
    assign frame_start  = frame_start_q;
    assign load_pending = pending_q;

    logic unused_state;
    assign unused_state = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_blank_en;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic        dp_n;
    logic        frame_start;
    logic        load_pending;

    int n_checks = 0;
    int n_errors = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .nibble_out  (nibble_out),
        .digit_en_n  (digit_en_n),
        .dp_n        (dp_n),
        .frame_start (frame_start),
        .load_pending(load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge where the frame's cycle 0 is visible; returns at the next frame's cycle 0.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] dp,
                               input logic [3:0] lit, input logic pend);
        logic [3:0] exp_nib;
        logic [3:0] exp_en;
        logic       exp_dp;
        int         d;
        int         k;
        for (int c = 0; c < 32; c++) begin
            d       = c / 8;
            k       = c % 8;
            exp_nib = val[d*4 +: 4];
            exp_en  = 4'hF;
            exp_dp  = 1'b1;
            if (k >= 2 && lit[d]) begin
                exp_en[d] = 1'b0;
                exp_dp    = ~dp[d];
            end
            check($sformatf("nib_c%0d", c), 32'(nibble_out), 32'(exp_nib));
            check($sformatf("en_c%0d", c), 32'(digit_en_n), 32'(exp_en));
            check($sformatf("dp_c%0d", c), 32'(dp_n), 32'(exp_dp));
            check($sformatf("fs_c%0d", c), 32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
            check($sformatf("pend_c%0d", c), 32'(load_pending), 32'(pend));
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dp);
        value_in = val;
        dp_in    = dp;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_fs", 32'(frame_start), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, 32'(digit_en_n), 32'hF);
        check({tag, "_dp"}, 32'(dp_n), 32'd1);
        check({tag, "_nib"}, 32'(nibble_out), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_pend"}, 32'(load_pending), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        value_in    = 16'h0;
        load        = 1'b0;
        dp_in       = 4'h0;
        lz_blank_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_frame(16'h0000, 4'h0, 4'hF, 1'b0);

        // Basic scan over two consecutive frames.
        do_load(16'h12AF, 4'h0);
        check("t1_pend", 32'(load_pending), 32'd1);
        wait_fs();
        check_frame(16'h12AF, 4'h0, 4'hF, 1'b0);
        check_frame(16'h12AF, 4'h0, 4'hF, 1'b0);

        // Leading-zero blanking.
        lz_blank_en = 1'b1;
        do_load(16'h0030, 4'h0);
        wait_fs();
        check_frame(16'h0030, 4'h0, 4'b0011, 1'b0);
        do_load(16'h0000, 4'h0);
        wait_fs();
        check_frame(16'h0000, 4'h0, 4'b0001, 1'b0);
        lz_blank_en = 1'b0;
        do_load(16'h0030, 4'h0);
        wait_fs();
        check_frame(16'h0030, 4'h0, 4'hF, 1'b0);

        // Decimal point on digit 2.
        do_load(16'h5678, 4'b0100);
        wait_fs();
        check_frame(16'h5678, 4'b0100, 4'hF, 1'b0);

        // Tear-free update: load in digit-2 DRIVE.
        do_load(16'h1111, 4'h0);
        wait_fs();
        repeat (19) @(negedge clk);
        value_in = 16'h2222;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("t3_en_d2", 32'(digit_en_n), 32'b1011);
        for (int c = 20; c < 32; c++) begin
            check($sformatf("t3_nib_c%0d", c), 32'(nibble_out), 32'h1);
            check($sformatf("t3_pend_c%0d", c), 32'(load_pending), 32'd1);
            @(negedge clk);
        end
        check_frame(16'h2222, 4'h0, 4'hF, 1'b0);

        // Load coincident with the transfer edge.
        do_load(16'h3333, 4'h0);
        repeat (30) @(negedge clk);
        value_in = 16'h4444;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check_frame(16'h3333, 4'h0, 4'hF, 1'b1);
        check_frame(16'h4444, 4'h0, 4'hF, 1'b0);

        // Reset mid-operation during digit-2 DRIVE.
        do_load(16'hABCD, 4'b1111);
        wait_fs();
        repeat (19) @(negedge clk);
        check("t6_pre_en", 32'(digit_en_n), 32'b1011);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_frame(16'h0000, 4'h0, 4'hF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Upstream stage of the hex-to-seven-segment decoder. It time-multiplexes a packed multi-digit hex value onto one shared decoder.
- Each cycle it presents one 4-bit nibble on nibble_out. Bit 3 drives the decoder's MSB input; bit 0 drives its LSB input.
- It drives active-low digit enables and an active-low decimal point.
- Loads are double-buffered, so a frame in progress never tears. Optional leading-zero blanking and an inter-digit blanking gap suppress ghosting.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (at least 1).
REFRESH_DIV, 50000, clock cycles per digit slot (at least 2).
BLANK_CYCLES, 100, leading cycles of each slot with all digits off (0 to REFRESH_DIV-1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; asynchronous assert, active-low.
value_in  input  4*NUM_DIGITS  packed hex value; nibble i = value_in[4i+3:4i]; digit 0 = least significant.
load  input  1  single-cycle strobe; captures value_in and dp_in into the shadow register.
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
lz_blank_en  input  1  enables leading-zero blanking; sampled live.
nibble_out  output  4  nibble for the current digit; feeds the decoder inputs.
digit_en_n  output  NUM_DIGITS  digit common enables, active-low.
dp_n  output  1  decimal point, active-low.
frame_start  output  1  one-cycle pulse at the first cycle of each digit-0 slot.
load_pending  output  1  shadow holds data not yet shown.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Counters: slot counter 0, digit index 0.
  - Registers: active and shadow registers 0; load_pending 0.
  - Outputs: digit_en_n all 1, dp_n 1, nibble_out 0, frame_start 0.
- Slot timing:
  - Each slot is exactly REFRESH_DIV cycles, in two states: BLANK for the first BLANK_CYCLES cycles, then DRIVE for the remaining cycles.
  - Digit index goes 0,1,…,NUM_DIGITS-1 and wraps to 0.
  - One frame = NUM_DIGITS*REFRESH_DIV cycles.
  - The first slot after reset release is digit 0. Its first output cycle is the cycle after the first rising clk edge with rst_n high.
- Outputs, all registered, no combinational path from inputs:
  - nibble_out = active nibble[idx] for the whole slot, BLANK included.
  - BLANK: digit_en_n all 1, dp_n 1.
  - DRIVE: only digit_en_n[idx] = 0, unless the digit is blanked. dp_n = ~active_dp[idx]; forced to 1 if the digit is blanked.
  - frame_start = 1 only in cycle 0 of each digit-0 slot. This applies to the first slot after reset as well.
- Double buffer:
  - load captures value_in and dp_in into the shadow on the edge where it is high. load_pending goes to 1 from the next cycle.
  - The shadow is copied to the active register on the edge that begins a digit-0 slot, only if load_pending is 1. The new value is visible from that frame_start cycle onward; load_pending clears in the same edge.
  - Load on that same edge: the transfer uses the old shadow, the shadow takes the new value, and load_pending stays 1. The new value appears in the following frame.
  - Multiple loads within a frame: the last one wins.
- Leading-zero blanking, with lz_blank_en = 1:
  - Digit i (i ≥ 1) is blanked when active nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked.
  - Blanked digits keep digit_en_n all 1 for their whole slot. Slot timing is unchanged.
- BLANK_CYCLES = 0: the DRIVE state covers the whole slot.
- Reset mid-operation: outputs return to reset values immediately without waiting for clk. Active, shadow and pending contents are discarded.

Test Plan:
All scenarios use NUM_DIGITS = 4, REFRESH_DIV = 8, BLANK_CYCLES = 2.
1. Basic scan: load 0x12AF, lz off, dp_in = 0 -> the frame after transfer shows nibble_out F, A, 2, 1 with digit_en_n 1110, 1101, 1011, 0111. Each digit is low 6 of its 8 cycles, then 1111 for 2 cycles. frame_start period is 32 cycles; dp_n stays 1.
2. Leading-zero blanking: load 0x0030, lz_blank_en = 1 -> digits 3 and 2 stay 1111 for their slots, digit 1 shows 3, digit 0 shows 0. Load 0x0000 -> only digit 0 lights, showing 0. Load 0x0030 with lz_blank_en = 0 -> all four digits light.
3. Tear-free update: active = 0x1111; load 0x2222 during the digit-2 DRIVE state -> digits 2 and 3 still show 1. load_pending is 1 until the next frame_start cycle, where digit 0 shows 2 and load_pending is 0.
4. Load coincident with transfer: pending 0x3333, load 0x4444 on the digit-0 slot-start edge -> that frame shows 3333 with load_pending still 1. The next frame shows 4444 and load_pending clears.
5. Decimal point: dp_in = 4'b0100 with a load -> dp_n is low only during the digit-2 DRIVE state (6 cycles per frame), and is 1 during BLANK.
6. Reset mid-operation: drop rst_n in the digit-2 DRIVE state -> without a clk edge, digit_en_n = 1111, dp_n = 1, nibble_out = 0, load_pending = 0. After release, frame_start pulses in the first output cycle and digit 0 shows 0.
